key_load_ctrl: RTL

KEY_LOAD_CTRL -- requirements
Module: key_load_ctrl

---
 rtl/key_load_ctrl_pkg.sv | 15 +
 rtl/key_load_ctrl_if.sv | 8 +
 rtl/key_load_ctrl_shift_reg.sv | 17 +
 rtl/key_load_ctrl.sv | 111 +++++++++++
 4 files changed

// File: rtl/key_load_ctrl_pkg.sv
// key_lock_pkg: shared FSM states, key widths and beat-count helper for key_load_ctrl.
package key_lock_pkg;
  localparam int KEY_X_W_DEF = 25;
  localparam int KEY_P_W_DEF = 4;
`ifdef KEY_PARITY_EN
  localparam int PAR_BEATS = 1;
`else
  localparam int PAR_BEATS = 0;
`endif
  localparam int KEY_BEATS = KEY_X_W_DEF + KEY_P_W_DEF + PAR_BEATS;
  typedef enum logic [2:0] {IDLE, FETCH, CHECK, APPLY, ERR} state_t;
  function automatic int beat_count(input int xw, input int pw);
    return xw + pw + PAR_BEATS;
  endfunction
endpackage

// File: rtl/key_load_ctrl_if.sv
// key_load_ctrl_if: serial key-store handshake (req/valid/data).
interface key_load_ctrl_if;
  logic kb_req;
  logic kb_valid;
  logic kb_data;
  modport master (output kb_req, input kb_valid, input kb_data);
  modport slave (input kb_req, output kb_valid, output kb_data);
endinterface

// File: rtl/key_load_ctrl_shift_reg.sv
// key_shift_reg: serial-in parallel-out shadow; first bit in ends at bit 0.
module key_shift_reg #(
  parameter int W = 29
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= '0;
    else q_q <= clr_i ? '0 : en_i ? {d_i, q_q[W-1:1]} : q_q;
  assign q_o = q_q;
endmodule

// File: rtl/key_load_ctrl.sv
// key_load_ctrl: fetches a serial key into a shadow register and applies it atomically to the locked c432.
// Define KEY_PARITY_EN to append an even-parity beat and enable the ERR path.
module key_load_ctrl
  import key_lock_pkg::*;
#(
  parameter int KEY_X_W = KEY_X_W_DEF,
  parameter int KEY_P_W = KEY_P_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  key_load_ctrl_if.master    kb,
  output logic [KEY_X_W-1:0] key_x_o,
  output logic [KEY_P_W-1:0] key_p_o,
  output logic               key_valid_o,
  output logic               busy_o,
  output logic               err_o
);
  localparam int W = KEY_X_W + KEY_P_W;
  localparam int NB = beat_count(KEY_X_W, KEY_P_W);
  localparam int CW = $clog2(NB + 1);
  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [W-1:0]       shadow;
  logic [KEY_X_W-1:0] key_x_q;
  logic [KEY_P_W-1:0] key_p_q;
  logic               kb_req_q, busy_q, key_valid_q;
  logic               xfer, restart;
`ifdef KEY_PARITY_EN
  logic               err_q, par_q;
`endif
  assign xfer = kb_req_q & kb.kb_valid;
  assign restart = start_i & (state_q == IDLE | state_q == ERR);
  // the parity beat passes through the handshake but is never stored
  key_shift_reg #(.W(W)) u_shadow (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (restart),
    .en_i  (xfer && cnt_q < CW'(W)),
    .d_i   (kb.kb_data),
    .q_o   (shadow)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      kb_req_q <= 1'b0;
      busy_q <= 1'b0;
      key_valid_q <= 1'b0;
      key_x_q <= '0;
      key_p_q <= '0;
`ifdef KEY_PARITY_EN
      err_q <= 1'b0;
      par_q <= 1'b0;
`endif
    end else
      case (state_q)
        IDLE, ERR:
          if (start_i) begin
            state_q <= FETCH;
            cnt_q <= '0;
            kb_req_q <= 1'b1;
            busy_q <= 1'b1;
`ifdef KEY_PARITY_EN
            err_q <= 1'b0;
            par_q <= 1'b0;
`endif
          end
        FETCH:
          if (xfer) begin
            cnt_q <= cnt_q + 1'b1;
`ifdef KEY_PARITY_EN
            par_q <= par_q ^ kb.kb_data;
`endif
            if (cnt_q == CW'(NB - 1)) begin
              state_q <= CHECK;
              kb_req_q <= 1'b0;
            end
          end
        CHECK:
`ifdef KEY_PARITY_EN
          if (par_q) begin
            state_q <= ERR;
            err_q <= 1'b1;
            busy_q <= 1'b0;
            key_valid_q <= 1'b0;
            key_x_q <= '0;
            key_p_q <= '0;
          end else
`endif
            state_q <= APPLY;
        APPLY: begin
          state_q <= IDLE;
          busy_q <= 1'b0;
          key_valid_q <= 1'b1;
          key_x_q <= shadow[KEY_X_W-1:0];
          key_p_q <= shadow[W-1:KEY_X_W];
        end
        default: state_q <= IDLE;
      endcase
  assign kb.kb_req = kb_req_q;
  assign key_x_o = key_x_q;
  assign key_p_o = key_p_q;
  assign key_valid_o = key_valid_q;
  assign busy_o = busy_q;
`ifdef KEY_PARITY_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif
endmodule
